// File: rtl/dm_pkg.sv
// Shared types and lane helpers for the data-memory access stage.
package dm_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  // Byte enables for a store of the given size at the given (aligned) lane.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Pull the addressed byte/half out of a RAM word and sign/zero extend it.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        lane,
                                                      input logic              is_unsigned);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{b[7] & ~is_unsigned}}, b};
      SZ_H:    r = {{16{h[15] & ~is_unsigned}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store byte enables/replication, load extraction/extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] ram_word,
  output logic [3:0]        byte_en_c,
  output logic [DATA_W-1:0] store_word_c,
  output logic [DATA_W-1:0] load_data_c
);

  always_comb begin
    byte_en_c    = byte_enable(size, lane);
    store_word_c = store_data;
    case (size)
      SZ_B:    store_word_c = {4{store_data[7:0]}};
      SZ_H:    store_word_c = {2{store_data[15:0]}};
      default: ;
    endcase
    load_data_c = load_extract(ram_word, size, lane, is_unsigned);
  end

endmodule

// File: rtl/dm_access_stage.sv
// DM pipeline stage: multi-cycle byte/half/word access to an internal word RAM with stall.
// Optional build macro MISALIGN_TRAP_EN flags misaligned half/word accesses instead of aligning them.
module dm_access_stage #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  output logic        stall,
  output logic [31:0] read_data,
  output logic [31:0] alu_res_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        misalign
);
  import dm_pkg::*;

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req_c;
  logic              mis_c;
  logic              commit_c;
  logic [1:0]        size_c;
  logic [1:0]        lane_c;
  logic [ADDR_W-1:0] idx_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] store_word_c;
  logic [DATA_W-1:0] load_data_c;

  // Request decode and alignment handling.
  always_comb begin
    req_c  = mem_read | mem_write;
    size_c = (mem_size == 2'd3) ? SZ_W : mem_size;
    idx_c  = alu_result[ADDR_W+1:2];
`ifdef MISALIGN_TRAP_EN
    mis_c  = ((size_c == SZ_H) && alu_result[0]) ||
             ((size_c == SZ_W) && (alu_result[1:0] != 2'b00));
    lane_c = alu_result[1:0];
`else
    mis_c  = 1'b0;
    case (size_c)
      SZ_B:    lane_c = alu_result[1:0];
      SZ_H:    lane_c = {alu_result[1], 1'b0};
      default: lane_c = 2'b00;
    endcase
`endif
  end

  dm_lane_align u_lane_align (
    .size         (size_c),
    .lane         (lane_c),
    .is_unsigned  (mem_unsigned),
    .store_data   (write_data),
    .ram_word     (mem_q[idx_c]),
    .byte_en_c    (be_c),
    .store_word_c (store_word_c),
    .load_data_c  (load_data_c)
  );

  // Next-state: IDLE -> (BUSY x MEM_LAT-1) -> DONE; commit on the edge into DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c && !mis_c) begin
          if (MEM_LAT == 1) begin
            state_d  = ST_DONE;
            commit_c = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(MEM_LAT - 2);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (commit_c) rd_d = mem_write ? '0 : load_data_c;
  end

  // Stage outputs; MEM/WB sees a bubble while stalled or trapped.
  always_comb begin
    stall          = rst_n && (((state_q == ST_IDLE) && req_c && !mis_c) || (state_q == ST_BUSY));
    misalign       = rst_n && (state_q == ST_IDLE) && req_c && mis_c;
    reg_write_out  = rst_n && reg_write && !stall && !misalign;
    read_data      = rd_q;
    alu_res_out    = alu_result;
    mem_to_reg_out = mem_to_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // RAM is not reset; a store held under reset never commits.
  always_ff @(posedge clk) begin
    if (rst_n && commit_c && mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= store_word_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_access_stage.sv
// Randomized + directed bench for dm_access_stage against a byte-array reference model.
module tb_dm_access_stage;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned NBYTES  = 4 * (2 ** ADDR_W);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, mem_unsigned, mem_to_reg, reg_write;
  logic [1:0]  mem_size;
  logic [31:0] alu_result, write_data;
  logic        stall, mem_to_reg_out, reg_write_out, misalign;
  logic [31:0] read_data, alu_res_out;

  logic [7:0]  model_mem [NBYTES];
  logic [31:0] exp_rd;
  int          pass_cnt = 0;
  int          total    = 0;

  always #5 clk = ~clk;

  dm_access_stage #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .alu_result     (alu_result),
    .write_data     (write_data),
    .mem_to_reg     (mem_to_reg),
    .reg_write      (reg_write),
    .stall          (stall),
    .read_data      (read_data),
    .alu_res_out    (alu_res_out),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_write_out  (reg_write_out),
    .misalign       (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // One pipeline instruction: drive, walk through its stall cycles, check the release cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic m2r, input logic rw);
    int   nb, n, base, exp_n;
    logic is_mem, mis;
    logic [31:0] v;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_result = addr; write_data = wdata; mem_to_reg = m2r; reg_write = rw;

    is_mem = rd | wr;
    nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis    = TRAP && is_mem && ((int'(addr[1:0]) % nb) != 0);
    base   = int'(addr[ADDR_W+1:0]) - (int'(addr[ADDR_W+1:0]) % nb);
    exp_n  = (is_mem && !mis) ? MEM_LAT : 0;
    if (is_mem && !mis) begin
      if (wr) begin
        for (int k = 0; k < nb; k++) model_mem[base + k] = wdata[8*k +: 8];
        exp_rd = '0;
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = model_mem[base + k];
        if (!uns) for (int k = 8 * nb; k < 32; k++) v[k] = v[8*nb - 1];
        exp_rd = v;
      end
    end

    #1;
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      chk("bubble_reg_write_out", 32'(reg_write_out), 32'd0);
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(exp_n));
    chk("reg_write_out", 32'(reg_write_out), 32'(rw && !mis));
    chk("misalign", 32'(misalign), 32'(mis));
    chk("read_data", read_data, exp_rd);
    chk("alu_res_out", alu_res_out, addr);
    chk("mem_to_reg_out", 32'(mem_to_reg_out), 32'(m2r));
  endtask

  initial begin
    logic [31:0] a;
    int          kind;

    // Reset with a request pending: no stall, no write-back, no misalign.
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
    alu_result = 32'h22; write_data = '0; mem_to_reg = 1'b1; reg_write = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_reg_write_out", 32'(reg_write_out), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    mem_read = 1'b0; reg_write = 1'b0; rst_n = 1'b1;
    #1;
    chk("rst_read_data", read_data, 32'd0);
    exp_rd = '0;

    // Prefill the low 256 bytes so every later load hits known data.
    for (int w = 0; w < 64; w++) do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, 1'b0, 1'b0);

    // Word store then load.
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
    chk("t1_lw", read_data, 32'hDEADBEEF);

    // Sub-word loads with sign/zero extension.
    do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1);
    chk("t2_lb", read_data, 32'hFFFFFFDE);
    do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 1'b1);
    chk("t2_lbu", read_data, 32'h000000DE);
    do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1);
    chk("t2_lh", read_data, 32'hFFFFDEAD);
    do_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b1, 1'b1);
    chk("t2_lhu", read_data, 32'h0000BEEF);

    // Sub-word stores merge into the word.
    do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
    chk("t3_sb", read_data, 32'hDEAD55EF);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h77771234, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
    chk("t3_sh", read_data, 32'h123455EF);

    // Non-memory op back-to-back with a load.
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);

    // Upper address bits wrap onto the same word.
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'hABCD_E010, 32'h0, 1'b1, 1'b1);
    chk("wrap_lw", read_data, 32'h123455EF);

    // Read and write together: store only, read_data cleared.
    do_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1, 1'b1);
    chk("rdwr_read_data", read_data, 32'h0);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1);
    chk("rdwr_stored", read_data, 32'hCAFEF00D);

    // Reset while the store is in flight drops it.
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd2; alu_result = 32'h20;
    write_data = 32'hFFFFFFFF; reg_write = 1'b0;
    #1;
    chk("t5_stall_req", 32'(stall), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_stall_rst", 32'(stall), 32'd0);
    chk("t5_rwo_rst", 32'(reg_write_out), 32'd0);
    @(negedge clk);
    mem_write = 1'b0; rst_n = 1'b1;
    #1;
    chk("t5_stall_idle", 32'(stall), 32'd0);
    chk("t5_read_data_rst", read_data, 32'd0);
    exp_rd = '0;
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1);

    // Misaligned word load (trapped or aligned down depending on build).
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 1'b1);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h25, 32'h0000BBBB, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1, 1'b1);

    // Random mix against the model.
    for (int i = 0; i < 120; i++) begin
      a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:    do_op(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                       1'($urandom), 1'($urandom));
        2, 3, 4, 5:
                 do_op(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                       1'b1, 1'($urandom));
        9:       do_op(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                       1'b0, 1'($urandom));
        default: do_op(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                       1'b0, 1'($urandom));
      endcase
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
